te_channel_ctrl: RTL and testbench
==================================

# te_channel_ctrl

Per-frame configuration controller for the transmission-estimation stage. It accepts the atmospheric light triple (A_R, A_G, A_B) from the atmospheric-light estimator and finds the minimum channel. It computes that channel's reciprocal with a serial divider and drives the channel-select and inverse-atmospheric-light values consumed by the Fc / Inv_Ac multiplexers. New configuration is double-buffered and only takes effect at a frame boundary, so the multiplexers never change selection mid-frame.

## Interface
Parameters:
- DIV_W, 17: dividend width; dividend constant is 2^(DIV_W-1) = 65536.
- INV_W, 16: reciprocal output width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  atmospheric light triple valid.
- a_ready  out  1  controller can accept a triple.
- a_r, a_g, a_b  in  8 each  atmospheric light per channel.
- frame_start  in  1  one-cycle pulse, first pixel of a new frame.
- sel  out  2  active channel select to both multiplexers (00 R, 01 G, 10 B; 11 never driven).
- inv_ac  out  16  active reciprocal, Q0.16 (floor(65536/A_min)), saturated.
- cfg_valid  out  1  high once at least one configuration has been committed.
- busy  out  1  high in CMP, DIV, DONE.

## Operation
- FSM states: IDLE, CMP, DIV, DONE.
  - IDLE: a_ready=1. On a_valid&&a_ready, latch a_r/a_g/a_b and go to CMP.
  - CMP, 1 cycle: select the minimum channel. Ties resolve to the lowest index (R over G over B). Register shadow_sel_next and divisor=A_min.
    - If A_min is 0 or 1, set the result to 16'hFFFF and go directly to DONE.
    - Otherwise start the divider and go to DIV.
  - DIV: restoring divide of 65536 by the 8-bit divisor, 1 quotient bit per cycle, 17 cycles. Quotient above 16'hFFFF saturates to 16'hFFFF. This is only reachable for divisor ≤1, which is already bypassed.
  - DONE, 1 cycle: write shadow_sel and shadow_inv, set pending=1, return to IDLE.
- Commit: on any edge where frame_start=1 and pending=1:
  - sel←shadow_sel, inv_ac←shadow_inv, cfg_valid←1, pending←0.
  - frame_start with pending=0 leaves the outputs unchanged.
- A new triple accepted while pending=1 is processed normally. Its DONE overwrites the shadow, so the latest result wins. An uncommitted result is never lost to a partial update, because shadow_sel and shadow_inv are written together.
- DONE and frame_start in the same cycle: the commit uses the old shadow if pending was already 1; otherwise nothing is committed. The new shadow waits for the next frame_start.
- a_valid while busy is ignored because a_ready=0. The source must hold it.
- Reset, asynchronous, in any state including mid-DIV:
  - State←IDLE, a_ready=1, sel=2'b00, inv_ac=16'hFFFF, cfg_valid=0, busy=0, pending=0, shadows cleared to 00/FFFF.
  - The divider state is discarded.

## Timing
- Handshake edge is T. CMP at T+1. DIV from T+2 to T+18. DONE edge at T+19, with pending visible after it. a_ready is high again at cycle T+20.
- Bypass path (A_min ≤1): DONE at T+2.
- Outputs are registered, with no combinational path from inputs to sel, inv_ac or cfg_valid.
- Outputs change only on a commit edge or on reset.

## Structure
- Package te_ctrl_pkg contains:
  - the state enum (IDLE, CMP, DIV, DONE);
  - SEL_R=2'b00, SEL_G=2'b01, SEL_B=2'b10;
  - INV_SAT=16'hFFFF and RECIP_NUM=17'h10000.
- Sub-module te_recip_div is the serial restoring divider.
  - Ports: clk, rst_n, start, divisor[7:0], done, quotient[15:0].
  - Fixed 17-cycle latency, saturating.
- Top level contains the FSM, the minimum compare, the shadow registers and the commit registers.

## Test plan
- Reset check: assert rst_n=0 then release. Required: sel=00, inv_ac=FFFF, cfg_valid=0, a_ready=1. frame_start with nothing pending leaves all outputs unchanged.
- Normal divide: send A=(200,150,180), then frame_start after DONE. Required: sel=01, inv_ac=436 (0x01B4), cfg_valid=1. a_ready must be low for exactly 19 cycles.
- Tie and full-scale cases:
  - A=(100,100,100) → sel=00, inv_ac=655.
  - A=(255,255,254) → sel=10, inv_ac=258.
- Bypass: A=(9,0,7) → sel=01, inv_ac=FFFF, DONE 2 cycles after the handshake. A=(1,5,5) → sel=00, inv_ac=FFFF.
- Boundary events:
  - frame_start coincident with DONE: the outputs hold and commit on the following frame_start.
  - Two triples before any frame_start: only the second is committed.
- Reset mid-DIV: at T+10, assert rst_n=0 for 1 cycle. Required: outputs return to reset values, no commit on the next frame_start, and a fresh triple completes correctly.

Source files
------------

// File: rtl/te_ctrl_pkg.sv
// Shared types and constants for the transmission-estimation channel controller.
// Contents: FSM state enum, channel-select codes, reciprocal constants,
// atmospheric-light triple payload and the minimum-channel helper.
package te_ctrl_pkg;

    localparam int unsigned A_W   = 8;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [SEL_W-1:0] SEL_R = 2'b00;
    localparam logic [SEL_W-1:0] SEL_G = 2'b01;
    localparam logic [SEL_W-1:0] SEL_B = 2'b10;

    localparam logic [15:0] INV_SAT   = 16'hFFFF;
    localparam logic [16:0] RECIP_NUM = 17'h10000;

    // Atmospheric light triple as delivered by the estimator.
    typedef struct packed {
        logic [A_W-1:0] r;
        logic [A_W-1:0] g;
        logic [A_W-1:0] b;
    } a_triple_t;

    // Minimum channel: which channel and its value.
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [A_W-1:0]   val;
    } min_t;

    // Strict less-than so ties keep the lower index (R over G over B).
    function automatic min_t find_min(input a_triple_t a);
        min_t m;
        m.sel = SEL_R;
        m.val = a.r;
        if (a.g < m.val) begin
            m.sel = SEL_G;
            m.val = a.g;
        end
        if (a.b < m.val) begin
            m.sel = SEL_B;
            m.val = a.b;
        end
        return m;
    endfunction

endpackage

// File: rtl/te_recip_div.sv
// Serial restoring divider: RECIP_NUM / divisor, one quotient bit per cycle.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start           load operands (divisor sampled on this edge)
//   divisor[7:0]    8-bit divisor
//   done            high during the final iteration cycle; quotient is
//                   valid from the following cycle
//   quotient[15:0]  saturated quotient
module te_recip_div
    import te_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W = 17,
    parameter int unsigned INV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [A_W-1:0]   divisor,
    output logic             done,
    output logic [INV_W-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(DIV_W + 1);

    logic [A_W-1:0]   r_div;
    logic [A_W-1:0]   r_rem;
    logic [DIV_W-1:0] r_dvd;
    logic [DIV_W-1:0] r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [INV_W-1:0] r_quotient;

    logic [A_W:0]     w_trial;
    logic             w_ge;
    logic [A_W-1:0]   w_diff;
    logic [A_W-1:0]   w_rem_next;
    logic [DIV_W-1:0] w_quo_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_last;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    // The remainder stays below the divisor, so the difference fits in A_W bits.
    assign w_trial    = {r_rem, r_dvd[DIV_W-1]};
    assign w_ge       = (w_trial >= {1'b0, r_div});
    assign w_diff     = A_W'(w_trial - {1'b0, r_div});
    assign w_rem_next = w_ge ? w_diff : w_trial[A_W-1:0];
    assign w_quo_next = {r_quo[DIV_W-2:0], w_ge};
    assign w_last     = (r_cnt == CNT_W'(1));

    always_comb begin
        w_cnt_next = r_cnt;
        if (start) begin
            w_cnt_next = CNT_W'(DIV_W);
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - CNT_W'(1);
        end
    end

    // Iteration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_quotient <= INV_W'(INV_SAT);
        end else begin
            r_cnt  <= w_cnt_next;
            r_done <= (w_cnt_next == CNT_W'(1));
            if (start) begin
                r_div <= divisor;
                r_rem <= '0;
                r_dvd <= DIV_W'(RECIP_NUM);
                r_quo <= '0;
            end else if (r_cnt != '0) begin
                r_rem <= w_rem_next;
                r_dvd <= {r_dvd[DIV_W-2:0], 1'b0};
                r_quo <= w_quo_next;
                // Final step: saturate anything that overflows INV_W bits.
                if (w_last) begin
                    r_quotient <= (|w_quo_next[DIV_W-1:INV_W]) ? INV_W'(INV_SAT)
                                                               : w_quo_next[INV_W-1:0];
                end
            end
        end
    end

    assign done     = r_done;
    assign quotient = r_quotient;

endmodule

// File: rtl/te_channel_ctrl.sv
// Per-frame configuration controller for transmission estimation.
// Finds the minimum atmospheric-light channel, computes its reciprocal and
// commits {sel, inv_ac} only at a frame boundary (double-buffered).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   a_valid/a_ready     triple handshake; a_r/a_g/a_b per-channel light
//   frame_start         first-pixel pulse; commits a pending configuration
//   sel                 active channel select (00 R, 01 G, 10 B)
//   inv_ac              active reciprocal Q0.16, saturated
//   cfg_valid           a configuration has been committed since reset
//   busy                processing a triple
module te_channel_ctrl
    import te_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W = 17,
    parameter int unsigned INV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [A_W-1:0]   a_r,
    input  logic [A_W-1:0]   a_g,
    input  logic [A_W-1:0]   a_b,
    input  logic             frame_start,
    output logic [SEL_W-1:0] sel,
    output logic [INV_W-1:0] inv_ac,
    output logic             cfg_valid,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_next;

    a_triple_t        r_a;
    logic [SEL_W-1:0] r_sel_next;
    logic             r_bypass;
    logic [SEL_W-1:0] r_shadow_sel;
    logic [INV_W-1:0] r_shadow_inv;
    logic             r_pending;
    logic [SEL_W-1:0] r_sel;
    logic [INV_W-1:0] r_inv;
    logic             r_cfg_valid;
    logic             r_a_ready;
    logic             r_busy;

    min_t             w_min;
    logic             w_accept;
    logic             w_div_start;
    logic             w_div_done;
    logic [INV_W-1:0] w_div_quo;
    logic             w_commit;

    assign w_min    = find_min(r_a);
    assign w_commit = frame_start && r_pending;

    te_recip_div #(
        .DIV_W (DIV_W),
        .INV_W (INV_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_div_start),
        .divisor  (w_min.val),
        .done     (w_div_done),
        .quotient (w_div_quo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_div_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (a_valid && r_a_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = CMP;
                end
            end
            CMP: begin
                // Divisors 0 and 1 would overflow Q0.16; skip the divider.
                if (w_min.val <= A_W'(1)) begin
                    w_state_next = DONE;
                end else begin
                    w_div_start  = 1'b1;
                    w_state_next = DIV;
                end
            end
            DIV: begin
                if (w_div_done) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture, shadow and commit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_sel_next   <= SEL_R;
            r_bypass     <= 1'b0;
            r_shadow_sel <= SEL_R;
            r_shadow_inv <= INV_W'(INV_SAT);
            r_pending    <= 1'b0;
            r_sel        <= SEL_R;
            r_inv        <= INV_W'(INV_SAT);
            r_cfg_valid  <= 1'b0;
            r_a_ready    <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_a_ready <= (w_state_next == IDLE);
            r_busy    <= (w_state_next != IDLE);

            if (w_accept) begin
                r_a <= '{r: a_r, g: a_g, b: a_b};
            end

            if (r_state == CMP) begin
                r_sel_next <= w_min.sel;
                r_bypass   <= (w_min.val <= A_W'(1));
            end

            // Commit samples the shadow before this edge's DONE update.
            if (w_commit) begin
                r_sel       <= r_shadow_sel;
                r_inv       <= r_shadow_inv;
                r_cfg_valid <= 1'b1;
            end

            // Shadow pair is written together; a fresh result re-arms pending.
            if (r_state == DONE) begin
                r_shadow_sel <= r_sel_next;
                r_shadow_inv <= r_bypass ? INV_W'(INV_SAT) : w_div_quo;
                r_pending    <= 1'b1;
            end else if (w_commit) begin
                r_pending    <= 1'b0;
            end
        end
    end

    assign a_ready   = r_a_ready;
    assign busy      = r_busy;
    assign sel       = r_sel;
    assign inv_ac    = r_inv;
    assign cfg_valid = r_cfg_valid;

endmodule

// File: tb/tb_te_channel_ctrl.sv
// Directed bench for te_channel_ctrl: vector table plus boundary sequences.
module tb_te_channel_ctrl;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic        a_ready;
    logic [7:0]  a_r;
    logic [7:0]  a_g;
    logic [7:0]  a_b;
    logic        frame_start;
    logic [1:0]  sel;
    logic [15:0] inv_ac;
    logic        cfg_valid;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Bench model of the committed configuration.
    int exp_sel;
    int exp_inv;
    int exp_cfg;

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [1:0]  sel;
        logic [15:0] inv;
        int          low;
    } vec_t;

    vec_t vecs[7];

    te_channel_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_r         (a_r),
        .a_g         (a_g),
        .a_b         (a_b),
        .frame_start (frame_start),
        .sel         (sel),
        .inv_ac      (inv_ac),
        .cfg_valid   (cfg_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_outputs(input string name);
        @(negedge clk);
        chk({name, ".sel"},       int'(sel),       exp_sel);
        chk({name, ".inv_ac"},    int'(inv_ac),    exp_inv);
        chk({name, ".cfg_valid"}, int'(cfg_valid), exp_cfg);
    endtask

    // Wait (bounded) for a_ready, then present one triple for a single edge.
    task automatic handshake(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!a_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hs_ready", int'(a_ready), 1);
        a_valid = 1'b1;
        a_r = r;
        a_g = g;
        a_b = b;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    // Count cycles with a_ready low after a handshake (bounded).
    task automatic wait_ready(output int low);
        low = 0;
        @(negedge clk);
        while (!a_ready && low < 100) begin
            low++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic run_triple(input string name, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input int sel_e, input int inv_e, input int low_e);
        int low;
        handshake(r, g, b);
        wait_ready(low);
        chk({name, ".ready_low_cycles"}, low, low_e);
        chk({name, ".busy_after"}, int'(busy), 0);
        chk_outputs({name, ".hold"});
        pulse_frame();
        exp_sel = sel_e;
        exp_inv = inv_e;
        exp_cfg = 1;
        chk_outputs({name, ".commit"});
    endtask

    initial begin
        int low;

        vecs[0] = '{r: 8'd200, g: 8'd150, b: 8'd180, sel: 2'b01, inv: 16'd436,   low: 19};
        vecs[1] = '{r: 8'd100, g: 8'd100, b: 8'd100, sel: 2'b00, inv: 16'd655,   low: 19};
        vecs[2] = '{r: 8'd255, g: 8'd255, b: 8'd254, sel: 2'b10, inv: 16'd258,   low: 19};
        vecs[3] = '{r: 8'd9,   g: 8'd0,   b: 8'd7,   sel: 2'b01, inv: 16'hFFFF,  low: 2};
        vecs[4] = '{r: 8'd1,   g: 8'd5,   b: 8'd5,   sel: 2'b00, inv: 16'hFFFF,  low: 2};
        vecs[5] = '{r: 8'd3,   g: 8'd2,   b: 8'd2,   sel: 2'b01, inv: 16'd32768, low: 19};
        vecs[6] = '{r: 8'd7,   g: 8'd9,   b: 8'd8,   sel: 2'b00, inv: 16'd9362,  low: 19};

        rst_n       = 1'b0;
        a_valid     = 1'b0;
        a_r         = '0;
        a_g         = '0;
        a_b         = '0;
        frame_start = 1'b0;
        exp_sel     = 0;
        exp_inv     = 16'hFFFF;
        exp_cfg     = 0;

        // Reset state and an empty frame_start.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_outputs("reset");
        chk("reset.a_ready", int'(a_ready), 1);
        chk("reset.busy", int'(busy), 0);
        pulse_frame();
        chk_outputs("idle_frame");

        // Table-driven triples, each committed by one frame_start.
        for (int i = 0; i < 7; i++) begin
            run_triple($sformatf("vec%0d", i), vecs[i].r, vecs[i].g, vecs[i].b,
                       int'(vecs[i].sel), int'(vecs[i].inv), vecs[i].low);
        end

        // frame_start on the DONE edge with nothing pending: no commit yet.
        handshake(8'd50, 8'd60, 8'd70);
        repeat (18) @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        @(negedge clk);
        chk("coinc.a_ready", int'(a_ready), 1);
        chk_outputs("coinc.hold");
        pulse_frame();
        exp_sel = 0;
        exp_inv = 1310;
        chk_outputs("coinc.commit");

        // Two triples before a frame_start: the later result wins.
        handshake(8'd40, 8'd30, 8'd20);
        wait_ready(low);
        chk("two.first_low", low, 19);
        handshake(8'd90, 8'd80, 8'd85);
        wait_ready(low);
        chk("two.second_low", low, 19);
        chk_outputs("two.hold");
        pulse_frame();
        exp_sel = 1;
        exp_inv = 819;
        chk_outputs("two.commit");
        pulse_frame();
        chk_outputs("two.no_pending");

        // Reset in the middle of a divide.
        handshake(8'd200, 8'd150, 8'd180);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_sel = 0;
        exp_inv = 16'hFFFF;
        exp_cfg = 0;
        chk_outputs("middiv.reset");
        chk("middiv.a_ready", int'(a_ready), 1);
        chk("middiv.busy", int'(busy), 0);
        pulse_frame();
        chk_outputs("middiv.no_commit");
        run_triple("middiv.fresh", 8'd10, 8'd20, 8'd30, 0, 6553, 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
